spi_mnrch: RTL and testbench



---
 rtl/spi_mnrch_pkg.sv | 9 +
 rtl/spi_sclk_gen.sv | 25 ++
 rtl/spi_mnrch.sv | 110 +++++++++++
 tb/tb_spi_mnrch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_mnrch_pkg.sv
// Shared types and constants for the spi_mnrch SPI master and its SCLK generator.
package spi_mnrch_pkg;
  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

  localparam int         DATA_W        = 16;
  localparam logic [4:0] SCLK_DIV_INIT = 5'b10111;
  localparam logic [4:0] SMPL_PT       = 5'b01111;
  localparam logic [4:0] SHFT_PT       = 5'b11111;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider (clk/32): ld preloads the phase so SCLK idles high and first falls 9 clks after release.
// smpl/shft are single-clk strobes one clk ahead of the SCLK rise/fall; no backpressure.
module spi_sclk_gen
  import spi_mnrch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ld,
  output logic sclk,
  output logic smpl,
  output logic shft
);

  logic [4:0] sclk_div;

  always_ff @(posedge clk) begin
    if (rst || ld) sclk_div <= SCLK_DIV_INIT;
    else           sclk_div <= sclk_div + 5'd1;
  end

  assign sclk = sclk_div[4];
  assign smpl = (sclk_div == SMPL_PT);
  assign shft = (sclk_div == SHFT_PT);

endmodule

// File: rtl/spi_mnrch.sv
// SPI master, one 16-bit full-duplex transfer per wrt pulse; done 521 clks after wrt, wrt while busy ignored.
// SPI_MNRCH_COLL_ERR_EN: a wrt while busy sets the sticky err flag (cleared by rst or the next accepted wrt).
module spi_mnrch
  import spi_mnrch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic              SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  state_t            state, nxt_state;
  logic [DATA_W-1:0] shft_reg;
  logic [3:0]        bit_cnt;
  logic              miso_smpl;
  logic              smpl, shft, sclk_ld;
  logic              load, do_shft, cnt_inc, finish;

  spi_sclk_gen u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .ld   (sclk_ld),
    .sclk (SCLK),
    .smpl (smpl),
    .shft (shft)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    do_shft   = 1'b0;
    cnt_inc   = 1'b0;
    finish    = 1'b0;
    sclk_ld   = 1'b0;
    case (state)
      IDLE: begin
        sclk_ld = 1'b1;
        if (wrt) begin
          load      = 1'b1;
          nxt_state = FRONT;
        end
      end
      // bit15 is already on MOSI, so the first fall carries no shift
      FRONT: if (shft) nxt_state = SHIFT;
      SHIFT: begin
        do_shft = shft;
        cnt_inc = shft;
        if (smpl && bit_cnt == 4'd15) nxt_state = BACK;
      end
      // last shift lands the 16th sample; preload stops SCLK before a 17th fall
      BACK: if (shft) begin
        do_shft   = 1'b1;
        finish    = 1'b1;
        sclk_ld   = 1'b1;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shft_reg  <= '0;
      bit_cnt   <= 4'd0;
      miso_smpl <= 1'b0;
      SS_n      <= 1'b1;
      done      <= 1'b0;
    end else begin
      if (load) begin
        shft_reg <= cmd;
        bit_cnt  <= 4'd0;
        SS_n     <= 1'b0;
        done     <= 1'b0;
      end else begin
        if (do_shft) shft_reg <= {shft_reg[DATA_W-2:0], miso_smpl};
        if (cnt_inc) bit_cnt  <= bit_cnt + 4'd1;
        if (finish) begin
          SS_n <= 1'b1;
          done <= 1'b1;
        end
      end
      if (smpl) miso_smpl <= MISO;
    end
  end

  assign MOSI    = shft_reg[DATA_W-1];
  assign rd_data = shft_reg;

`ifdef SPI_MNRCH_COLL_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)      err <= 1'b0;
    else if (wrt) err <= (state != IDLE);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mnrch.sv
// Directed bench for spi_mnrch: mode-3 slave model, waveform timing, reset abort, collision, back-to-back.
module tb_spi_mnrch;

  logic        clk = 1'b0;
  logic        rst, wrt, miso;
  logic [15:0] cmd, rd_data;
  logic        done, err, ss_n, sclk, mosi;

  always #5 clk = ~clk;

  spi_mnrch dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .err     (err),
    .SS_n    (ss_n),
    .SCLK    (sclk),
    .MOSI    (mosi),
    .MISO    (miso)
  );

`ifdef SPI_MNRCH_COLL_ERR_EN
  localparam logic COLL_EN = 1'b1;
`else
  localparam logic COLL_EN = 1'b0;
`endif

  // Slave: drives its next bit on each SCLK fall, captures MOSI on each rise.
  logic [15:0] slv_resp, slv_out, slv_in;
  logic [7:0]  slv_reg [0:127];
  logic        miso_bit = 1'b1;
  int          slv_falls = 0, slv_rises = 0, fall_base = 0, rise_base = 0;

  always @(negedge ss_n) begin
    fall_base = slv_falls;
    rise_base = slv_rises;
    slv_out   = slv_resp;
  end

  always @(negedge sclk) begin
    int k;
    slv_falls++;
    k = slv_falls - fall_base;
    if (!ss_n && k >= 1 && k <= 16) miso_bit = slv_out[16-k];
  end

  always @(posedge sclk) begin
    slv_rises++;
    slv_in = {slv_in[14:0], mosi};
  end

  always @(posedge ss_n) begin
    if (slv_rises - rise_base == 16 && !slv_in[15]) slv_reg[slv_in[14:8]] = slv_in[7:0];
  end

  assign miso = ss_n ? 1'b1 : miso_bit;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int          r_done, r_falls, r_rises, r_ffall, r_lfall, r_lrise, r_badper, r_viol, r_ssrise;
  logic [15:0] r_mosi;

  // Called at a negedge; edge 0 is the next posedge. Returns at the negedge after done (or abort).
  task automatic xfer(input string tag, input logic [15:0] c, input int rst_at, input int coll_at);
    logic ps, pss;
    r_done = -1; r_falls = 0; r_rises = 0; r_ffall = -1; r_lfall = -1; r_lrise = -1;
    r_badper = 0; r_viol = 0; r_ssrise = -1; r_mosi = 16'h0;
    cmd = c;
    wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    check({tag, ":done_drop"}, {31'b0, done}, 32'd0);
    check({tag, ":ss_low"},    {31'b0, ss_n}, 32'd0);
    check({tag, ":err_clr"},   {31'b0, err},  32'd0);
    ps  = sclk;
    pss = ss_n;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (n == rst_at) begin
        check({tag, ":rst_ss"},   {31'b0, ss_n}, 32'd1);
        check({tag, ":rst_sclk"}, {31'b0, sclk}, 32'd1);
        check({tag, ":rst_done"}, {31'b0, done}, 32'd0);
        check({tag, ":rst_data"}, {16'b0, rd_data}, 32'd0);
        rst = 1'b0;
        return;
      end
      if (n == rst_at - 1) rst = 1'b1;
      if (n == coll_at - 1) begin wrt = 1'b1; cmd = 16'hFFFF; end
      if (n == coll_at)     begin wrt = 1'b0; cmd = c;        end
      if (ps && !sclk) begin
        r_falls++;
        if (r_ffall < 0) r_ffall = n;
        else if (n - r_lfall != 32) r_badper++;
        r_lfall = n;
      end
      if (!ps && sclk) begin
        r_rises++;
        if (r_lrise >= 0 && n - r_lrise != 32) r_badper++;
        r_lrise = n;
        r_mosi  = {r_mosi[14:0], mosi};
      end
      if (ss_n && !pss && r_ssrise < 0) r_ssrise = n;
      if (ss_n && !sclk) r_viol++;
      ps  = sclk;
      pss = ss_n;
      if (done) begin
        r_done = n;
        break;
      end
    end
  endtask

  task automatic chk_wave(input string tag, input logic [15:0] c);
    check({tag, ":done_edge"}, r_done,   32'd521);
    check({tag, ":ss_rise"},   r_ssrise, 32'd521);
    check({tag, ":falls"},     r_falls,  32'd16);
    check({tag, ":rises"},     r_rises,  32'd16);
    check({tag, ":first_fall"}, r_ffall, 32'd9);
    check({tag, ":last_fall"}, r_lfall,  32'd489);
    check({tag, ":last_rise"}, r_lrise,  32'd505);
    check({tag, ":period"},    r_badper, 32'd0);
    check({tag, ":sclk_idle"}, r_viol,   32'd0);
    check({tag, ":mosi_seq"},  {16'b0, r_mosi}, {16'b0, c});
  endtask

  initial begin
    rst = 1'b1; wrt = 1'b0; cmd = 16'h0; slv_resp = 16'h0;
    repeat (3) @(negedge clk);
    check("reset:ss",   {31'b0, ss_n},    32'd1);
    check("reset:sclk", {31'b0, sclk},    32'd1);
    check("reset:mosi", {31'b0, mosi},    32'd0);
    check("reset:done", {31'b0, done},    32'd0);
    check("reset:data", {16'b0, rd_data}, 32'd0);
    check("reset:err",  {31'b0, err},     32'd0);
    rst = 1'b0;

    // read PTCH
    slv_resp = 16'h1234;
    xfer("read", 16'hA200, 0, 0);
    chk_wave("read", 16'hA200);
    check("read:data",    {16'b0, rd_data}, 32'h1234);
    check("read:lo_byte", {24'b0, rd_data[7:0]}, 32'h34);

    // write reg 0x0D, then back-to-back read of ROLL
    slv_resp = 16'h00A5;
    xfer("write", 16'h0D02, 0, 0);
    chk_wave("write", 16'h0D02);
    check("write:slv_reg", {24'b0, slv_reg[7'h0D]}, 32'h02);
    check("write:hi_byte", {24'b0, rd_data[15:8]}, 32'h00);
    check("write:lo_byte", {24'b0, rd_data[7:0]},  32'hA5);
    slv_resp = 16'h5678;
    xfer("b2b", 16'hA400, 0, 0);
    chk_wave("b2b", 16'hA400);
    check("b2b:roll_lo", {24'b0, rd_data[7:0]}, 32'h78);
    check("b2b:data",    {16'b0, rd_data},      32'h5678);

    // reset at edge 200, then a fresh read
    slv_resp = 16'h9999;
    xfer("abort", 16'h1234, 200, 0);
    check("abort:err", {31'b0, err}, 32'd0);
    slv_resp = 16'h1234;
    xfer("fresh", 16'hA200, 0, 0);
    chk_wave("fresh", 16'hA200);
    check("fresh:data", {16'b0, rd_data}, 32'h1234);

    // colliding wrt at edge 100
    slv_resp = 16'hBEEF;
    xfer("coll", 16'h8100, 0, 100);
    chk_wave("coll", 16'h8100);
    check("coll:data", {16'b0, rd_data}, 32'hBEEF);
    check("coll:err",  {31'b0, err},     {31'b0, COLL_EN});
    slv_resp = 16'h1234;
    xfer("after", 16'hA200, 0, 0);
    check("after:done_edge", r_done, 32'd521);
    check("after:data", {16'b0, rd_data}, 32'h1234);
    check("after:err",  {31'b0, err},     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
